// File: rtl/fifo_serial_tx_if.sv
// FIFO read-port bundle between the serial transmitter (master) and the 64x8 FIFO (slave).
interface fifo_serial_tx_if;
  logic       fifo_rd;
  logic       fifo_empty;
  logic [7:0] fifo_data;

  modport master (output fifo_rd, input fifo_empty, input fifo_data);
  modport slave  (input fifo_rd, output fifo_empty, output fifo_data);
endinterface

// File: rtl/fifo_serial_tx.sv
// Drains the FIFO and sends each byte as a start/8N/stop serial frame on tx_o.
// Optional even-parity bit before the stop bit when FIFO_SERIAL_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for en_i with data available
// POP    | fifo_rd high for one cycle
// LOAD   | FIFO data valid, captured into the shift register
// START  | start bit (low)
// DATA   | eight data bits, LSB first
// PARITY | even parity over the captured byte (optional build)
// STOP   | stop bit (high); frame_done on its last cycle
module fifo_serial_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  fifo_serial_tx_if.master     fifo,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 frame_done_o,
  output logic [CNT_W-1:0]     bytes_sent_o
);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    LOAD,
    START,
    DATA,
`ifdef FIFO_SERIAL_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  localparam logic [15:0] LAST    = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] LAST_M1 = 16'(CLKS_PER_BIT - 2);

  state_t           state_q;
  logic [15:0]      cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             tx_q;
  logic             rd_q;
  logic             busy_q;
  logic             frame_done_q;
  logic [CNT_W-1:0] bytes_q;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  logic             par_q;
`endif

  logic bit_end;
  logic can_pop;
  assign bit_end = (cnt_q == LAST);
  assign can_pop = en_i && !fifo.fifo_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      tx_q         <= 1'b1;
      rd_q         <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      bytes_q      <= '0;
`ifdef FIFO_SERIAL_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      rd_q         <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q  <= 1'b1;
          cnt_q <= '0;
          if (can_pop) begin
            state_q <= POP;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        POP: state_q <= LOAD;
        LOAD: begin
          shift_q   <= fifo.fifo_data;
`ifdef FIFO_SERIAL_TX_PARITY_EN
          par_q     <= ^fifo.fifo_data;
`endif
          bit_idx_q <= '0;
          cnt_q     <= '0;
          tx_q      <= 1'b0;
          state_q   <= START;
        end
        START: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
              tx_q    <= par_q;
              state_q <= PARITY;
`else
              tx_q    <= 1'b1;
              state_q <= STOP;
`endif
            end else begin
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`ifdef FIFO_SERIAL_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
`endif
        STOP: begin
          // registered pulse must rise one cycle early to land on the last stop cycle
          if (cnt_q == LAST_M1) frame_done_q <= 1'b1;
          if (bit_end) begin
            cnt_q   <= '0;
            bytes_q <= bytes_q + CNT_W'(1);
            if (can_pop) begin
              state_q <= POP;
              rd_q    <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign fifo.fifo_rd = rd_q;
  assign tx_o         = tx_q;
  assign busy_o       = busy_q;
  assign frame_done_o = frame_done_q;
  assign bytes_sent_o = bytes_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: FIFO model, per-cycle schedule reference, directed and random phases.
module tb_fifo_serial_tx;
  localparam int CPB = 4;
  localparam int CW  = 4;
`ifdef FIFO_SERIAL_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = 2 + NBITS * CPB;

  typedef struct packed { logic tx; logic rd; logic fd; logic busy; } rec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          en = 1'b0;
  logic          tx, busy, fd;
  logic [CW-1:0] bs;

  fifo_serial_tx_if fif ();

  fifo_serial_tx #(.CLKS_PER_BIT(CPB), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .en_i(en), .fifo(fif),
    .tx_o(tx), .busy_o(busy), .frame_done_o(fd), .bytes_sent_o(bs)
  );

  always #5 clk = ~clk;

  int         assertions = 0;
  int         failures = 0;
  logic [7:0] fq[$];
  rec_t       sched[$];
  int         exp_cnt = 0;
  int         rd_pulses = 0;
  int         fd_pulses = 0;
  int         busy_cycles = 0;
  bit         txlog[$];
  logic       rd_at_neg = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one frame, from POP through the last stop cycle.
  function automatic void build(input logic [7:0] b);
    logic v;
    sched.push_back('{tx: 1'b1, rd: 1'b1, fd: 1'b0, busy: 1'b1});
    sched.push_back('{tx: 1'b1, rd: 1'b0, fd: 1'b0, busy: 1'b1});
    for (int k = 0; k < NBITS; k++) begin
      if (k == 0) v = 1'b0;
      else if (k <= 8) v = b[k-1];
      else if (k == NBITS - 1) v = 1'b1;
      else v = ^b;
      for (int c = 0; c < CPB; c++)
        sched.push_back('{tx: v, rd: 1'b0, fd: (k == NBITS - 1 && c == CPB - 1), busy: 1'b1});
    end
  endfunction

  initial begin
    fif.fifo_empty = 1'b1;
    fif.fifo_data  = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rd_at_neg && fq.size() > 0) fif.fifo_data = fq.pop_front();
      else fif.fifo_data = 8'($urandom);
      fif.fifo_empty = (fq.size() == 0);
    end
  end

  always @(negedge clk) begin
    rec_t e;
    rec_t cur;
    if (sched.size() > 0) e = sched[0];
    else e = '{tx: 1'b1, rd: 1'b0, fd: 1'b0, busy: 1'b0};
    chk("tx", {31'b0, tx}, {31'b0, e.tx});
    chk("fifo_rd", {31'b0, fif.fifo_rd}, {31'b0, e.rd});
    chk("frame_done", {31'b0, fd}, {31'b0, e.fd});
    chk("busy", {31'b0, busy}, {31'b0, e.busy});
    chk("bytes_sent", 32'(bs), 32'(exp_cnt % (1 << CW)));
    chk("rd_while_empty", {31'b0, fif.fifo_rd & fif.fifo_empty}, 32'd0);
    if (fif.fifo_rd === 1'b1) rd_pulses++;
    if (fd === 1'b1) fd_pulses++;
    if (busy === 1'b1) busy_cycles++;
    txlog.push_back(tx);
    rd_at_neg = fif.fifo_rd;
    if (reset) begin
      sched.delete();
      exp_cnt = 0;
    end else begin
      if (sched.size() > 0) begin
        cur = sched.pop_front();
        if (cur.fd) exp_cnt++;
      end
      if (sched.size() == 0 && en && !fif.fifo_empty && fq.size() > 0) build(fq[0]);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((busy !== 1'b0 || sched.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    assertions++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] txat(input int idx);
    if (idx < txlog.size()) return {31'b0, txlog[idx]};
    return 32'hFFFF_FFFF;
  endfunction

  bit exp_a5[NBITS];
  int r0, f0, b0, bc0, n;

  initial begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
    exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
    exp_a5 = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
`endif
    // reset with data present, en low
    fq.push_back(8'h55);
    tick(3);
    reset = 1'b0;
    tick(1);
    chk("t1_bytes_sent", 32'(bs), 32'd0);
    chk("t1_busy", {31'b0, busy}, 32'd0);
    chk("t1_tx", {31'b0, tx}, 32'd1);
    chk("t1_rd", {31'b0, fif.fifo_rd}, 32'd0);
    fq.delete();
    tick(2);

    // single 0xA5 frame
    fq.push_back(8'hA5);
    tick(1);
    r0 = rd_pulses; f0 = fd_pulses; b0 = txlog.size();
    en = 1'b1;
    tick(2);
    wait_idle("t2_idle", 200);
    en = 1'b0;
    chk("t2_rd_pulses", 32'(rd_pulses - r0), 32'd1);
    chk("t2_frame_done", 32'(fd_pulses - f0), 32'd1);
    chk("t2_bytes_sent", 32'(bs), 32'd1);
    chk("t2_before_start", txat(b0 + 2), 32'd1);
    for (int k = 0; k < NBITS; k++)
      chk($sformatf("t2_bit%0d", k), txat(b0 + 3 + k * CPB), {31'b0, exp_a5[k]});

    // three back-to-back frames
    pulse_reset();
    fq.push_back(8'h00); fq.push_back(8'hFF); fq.push_back(8'h3C);
    tick(1);
    r0 = rd_pulses; bc0 = busy_cycles;
    en = 1'b1;
    tick(2);
    wait_idle("t3_idle", 400);
    en = 1'b0;
    chk("t3_bytes_sent", 32'(bs), 32'd3);
    chk("t3_busy", {31'b0, busy}, 32'd0);
    chk("t3_empty", {31'b0, fif.fifo_empty}, 32'd1);
    chk("t3_rd_pulses", 32'(rd_pulses - r0), 32'd3);
    chk("t3_busy_cycles", 32'(busy_cycles - bc0), 32'(3 * FRAME));

    // en dropped during DATA
    pulse_reset();
    fq.push_back(8'h11); fq.push_back(8'h22);
    tick(1);
    r0 = rd_pulses;
    en = 1'b1;
    tick(3 + CPB * 3);
    en = 1'b0;
    wait_idle("t4_idle", 200);
    tick(5);
    chk("t4_rd_pulses", 32'(rd_pulses - r0), 32'd1);
    chk("t4_bytes_sent", 32'(bs), 32'd1);
    chk("t4_fifo_left", 32'(fq.size()), 32'd1);
    fq.delete();
    tick(2);

    // reset during DATA bit 3
    pulse_reset();
    fq.push_back(8'h5A); fq.push_back(8'h77);
    tick(1);
    r0 = rd_pulses;
    en = 1'b1;
    tick(3 + CPB * 4);
    reset = 1'b1;
    en = 1'b0;
    tick(1);
    reset = 1'b0;
    chk("t5_tx", {31'b0, tx}, 32'd1);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_bytes_sent", 32'(bs), 32'd0);
    tick(10);
    chk("t5_no_rd", 32'(rd_pulses - r0), 32'd1);
    en = 1'b1;
    tick(2);
    wait_idle("t5_idle", 200);
    en = 1'b0;
    chk("t5_bytes_after", 32'(bs), 32'd1);

    // counter wrap
    pulse_reset();
    for (int k = 0; k < 17; k++) fq.push_back(8'($urandom));
    tick(1);
    f0 = fd_pulses;
    en = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      n = 0;
      while (fd_pulses - f0 < k && n < 4 * FRAME) begin tick(1); n++; end
      assertions++;
      if (n >= 4 * FRAME) begin
        failures++;
        $display("FAIL t6_frame%0d: no frame_done within %0d cycles", k, 4 * FRAME);
      end
      chk($sformatf("t6_count%0d", k), 32'(bs), 32'(k % 16));
    end
    chk("t6_after15", 32'(exp_cnt), 32'd17);
    en = 1'b0;
    wait_idle("t6_idle", 200);
    chk("t6_final", 32'(bs), 32'h1);

    // randomized traffic
    pulse_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0 && fq.size() < 64) fq.push_back(8'($urandom));
      if ($urandom_range(39) == 0) en = ~en;
      if ($urandom_range(499) == 0) pulse_reset();
      else tick(1);
    end
    en = 1'b1;
    tick(2);
    while (fq.size() > 0 && n < 4000) begin tick(1); n++; end
    wait_idle("rand_drain", 4000);
    en = 1'b0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
